// File: rtl/sseg_scan_n.sv
// sseg_scan_n: N-digit multiplexed common-anode seven-segment driver.
// Frame-snapshotted data, leading-zero blanking, per-digit blink, PWM dimming.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   data          packed hex nibbles, digit i = data[4*i+3:4*i], digit 0 rightmost
//   dp_en         per-digit decimal point enable
//   blank_lz      blank leading zeros (digit 0 always shown)
//   blink_mask    per-digit blink enable
//   brightness    duty level, 0 = dark, 15 = full on (sampled live)
//   seg, dp, an   active-low segment {g..a}, decimal point and anode outputs
module sseg_scan_n #(
   parameter int N_DIGITS   = 4,
   parameter int DIV_LOG2   = 16,
   parameter int BLINK_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] data,
   input  logic [N_DIGITS-1:0]   dp_en,
   input  logic                  blank_lz,
   input  logic [N_DIGITS-1:0]   blink_mask,
   input  logic [3:0]            brightness,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   an
);

   localparam int IW = $clog2(N_DIGITS);
   localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);

   logic [DIV_LOG2-1:0]   pcnt;
   logic [IW-1:0]         idx;
   logic [BLINK_LOG2-1:0] fcnt;

   logic [4*N_DIGITS-1:0] snap_data;
   logic [N_DIGITS-1:0]   snap_dp;
   logic [N_DIGITS-1:0]   snap_blink;
   logic                  snap_blz;

   logic                  tick;
   logic                  frame_end;
   logic [3:0]            digit;
   logic                  sel_dp;
   logic                  sel_blink;
   logic                  upper_nz;
   logic                  lz_blank;
   logic                  bl_blank;
   logic                  seg_on;
   logic                  dp_on;
   logic [3:0]            pwr;
   logic                  lit;
   logic [N_DIGITS-1:0]   an_next;

   function automatic logic [6:0] decode(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick      = &pcnt;
   assign frame_end = tick && (idx == LAST);
   assign pwr       = pcnt[DIV_LOG2-1 -: 4];

   always_comb begin
      digit     = '0;
      sel_dp    = 1'b0;
      sel_blink = 1'b0;
      upper_nz  = 1'b0;
      an_next   = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            digit     = snap_data[4*i +: 4];
            sel_dp    = snap_dp[i];
            sel_blink = snap_blink[i];
         end
         // Any nonzero nibble at or above the current digit stops LZ blanking.
         if (IW'(i) >= idx && snap_data[4*i +: 4] != 4'h0)
            upper_nz = 1'b1;
      end
      lz_blank = snap_blz && (idx != '0) && !upper_nz;
      bl_blank = sel_blink && fcnt[BLINK_LOG2-1];
      seg_on   = !lz_blank && !bl_blank;
      dp_on    = sel_dp && !bl_blank;
      lit      = (brightness == 4'hF) || (pwr < brightness);
      for (int i = 0; i < N_DIGITS; i++)
         if (lit && idx == IW'(i))
            an_next[i] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt       <= '0;
         idx        <= '0;
         fcnt       <= '0;
         snap_data  <= '0;
         snap_dp    <= '0;
         snap_blink <= '0;
         snap_blz   <= 1'b0;
         an         <= '1;
         seg        <= 7'h7F;
         dp         <= 1'b1;
      end else begin
         pcnt <= pcnt + DIV_LOG2'(1);
         if (tick)
            idx <= (idx == LAST) ? '0 : idx + IW'(1);
         // Latch the next frame's content only at the frame boundary.
         if (frame_end) begin
            fcnt       <= fcnt + BLINK_LOG2'(1);
            snap_data  <= data;
            snap_dp    <= dp_en;
            snap_blink <= blink_mask;
            snap_blz   <= blank_lz;
         end
         an  <= an_next;
         seg <= (lit && seg_on) ? decode(digit) : 7'h7F;
         dp  <= !(lit && dp_on);
      end
   end

endmodule

// File: tb/tb_sseg_scan_n.sv
// tb_sseg_scan_n: randomized and directed bench for sseg_scan_n.
// Outputs are compared every cycle against a time-indexed behavioural model.
module tb_sseg_scan_n;

   localparam int ND    = 4;
   localparam int DL    = 4;
   localparam int BL    = 2;
   localparam int SLOT  = 1 << DL;
   localparam int FRAME = SLOT * ND;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4*ND-1:0] data = '0;
   logic [ND-1:0] dp_en = '0;
   logic          blank_lz = 1'b0;
   logic [ND-1:0] blink_mask = '0;
   logic [3:0]    brightness = 4'hF;
   logic [6:0]    seg;
   logic          dp;
   logic [ND-1:0] an;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sseg_scan_n #(.N_DIGITS(ND), .DIV_LOG2(DL), .BLINK_LOG2(BL)) dut (
      .clk(clk), .rst(rst), .data(data), .dp_en(dp_en),
      .blank_lz(blank_lz), .blink_mask(blink_mask),
      .brightness(brightness), .seg(seg), .dp(dp), .an(an)
   );

   logic [6:0] dec_tab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // Model: mk counts clock edges since reset; everything follows from it.
   int          mk = 0;
   int          m_pc, m_id, m_f;
   bit          m_ph, m_lit, m_lz, m_bl;
   logic [15:0] s_data;
   logic [ND-1:0] s_dp, s_blink;
   logic        s_blz;
   logic [ND-1:0] e_an;
   logic [6:0]  e_seg;
   logic        e_dp;
   bit          e_valid = 0;

   always @(posedge clk) begin
      if (rst) begin
         mk = 0;
         s_data = '0; s_dp = '0; s_blink = '0; s_blz = 1'b0;
         e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         m_pc  = mk % SLOT;
         m_id  = (mk / SLOT) % ND;
         m_f   = mk / FRAME;
         m_ph  = (m_f % (1 << BL)) >= (1 << (BL - 1));
         m_lit = (brightness == 4'hF) || ((m_pc >> (DL - 4)) < brightness);
         m_lz  = s_blz && m_id != 0 && ((s_data >> (4 * m_id)) == 0);
         m_bl  = s_blink[m_id] && m_ph;
         e_an  = m_lit ? ~(ND'(1) << m_id) : '1;
         e_seg = (m_lit && !m_lz && !m_bl) ? dec_tab[s_data[4*m_id +: 4]]
                                           : 7'h7F;
         e_dp  = !(m_lit && s_dp[m_id] && !m_bl);
         if (mk % FRAME == FRAME - 1) begin
            s_data = data; s_dp = dp_en;
            s_blink = blink_mask; s_blz = blank_lz;
         end
         mk++;
      end
      e_valid = 1;
   end

   always @(negedge clk) begin
      if (e_valid) begin
         chk("an", 32'(an), 32'(e_an));
         chk("seg", 32'(seg), 32'(e_seg));
         chk("dp", 32'(dp), 32'(e_dp));
         chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
         if (an == '1)
            chk("idle_segdp", 32'({seg, dp}), 32'({7'h7F, 1'b1}));
      end
   end

   task automatic go_edge(input int e);
      int n = 0;
      while (mk != e + 1) begin
         @(negedge clk);
         n++;
         if (n > 5000) begin
            checks++; errors++;
            $display("FAIL go_edge timeout target %0d mk %0d", e, mk);
            return;
         end
      end
   endtask

   task automatic restart();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic count_an(input int e0, input int n, input logic [ND-1:0] v,
                           output int cnt);
      go_edge(e0);
      cnt = 0;
      repeat (n) begin
         if (an == v) cnt++;
         @(negedge clk);
      end
   endtask

   task automatic lit_chk(input int e, input string name,
                          input logic [ND-1:0] a, input logic [6:0] s,
                          input logic d);
      go_edge(e);
      chk({name, "_an"}, 32'(an), 32'(a));
      chk({name, "_seg"}, 32'(seg), 32'(s));
      chk({name, "_dp"}, 32'(dp), 32'(d));
   endtask

   int cnt;

   initial begin
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      repeat (1500) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0)
            for (int i = 0; i < ND; i++)
               data[4*i +: 4] = $urandom_range(0, 1) ? 4'h0
                                : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) dp_en = ND'($urandom);
         if ($urandom_range(0, 7) == 0) blink_mask = ND'($urandom);
         if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
         if ($urandom_range(0, 7) == 0) brightness = 4'($urandom);
         rst = ($urandom_range(0, 499) == 0);
      end

      // Reset mid-scan, then plain scan of 12AF at full brightness.
      data = 16'h12AF; dp_en = '0; blink_mask = '0; blank_lz = 1'b0;
      brightness = 4'hF; rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_an", 32'(an), 32'h0000000F);
      chk("rst_seg", 32'(seg), 32'h0000007F);
      chk("rst_dp", 32'(dp), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_an", 32'(an), 32'h0000000E);
      chk("rel_seg", 32'(seg), 32'h00000040);
      count_an(64, 16, 4'hE, cnt);
      chk("full_duty", 32'(cnt), 32'd16);
      lit_chk(80, "d1", 4'hD, 7'h08, 1'b1);
      lit_chk(96, "d2", 4'hB, 7'h24, 1'b1);
      lit_chk(112, "d3", 4'h7, 7'h79, 1'b1);
      brightness = 4'd4;
      count_an(128, 16, 4'hE, cnt);
      chk("duty4", 32'(cnt), 32'd4);
      brightness = 4'd0;
      count_an(192, 64, 4'hF, cnt);
      chk("dark", 32'(cnt), 32'd64);
      brightness = 4'hF;

      // Leading-zero blanking.
      data = 16'h0050; blank_lz = 1'b1;
      restart();
      lit_chk(64, "lz0", 4'hE, 7'h40, 1'b1);
      lit_chk(80, "lz1", 4'hD, 7'h12, 1'b1);
      lit_chk(96, "lz2", 4'hB, 7'h7F, 1'b1);
      lit_chk(112, "lz3", 4'h7, 7'h7F, 1'b1);
      data = 16'h0000;
      restart();
      lit_chk(64, "z0", 4'hE, 7'h40, 1'b1);
      lit_chk(80, "z1", 4'hD, 7'h7F, 1'b1);

      // Mid-frame data change must wait for the frame boundary.
      data = 16'h1234; blank_lz = 1'b0;
      restart();
      go_edge(84);
      data = 16'h5678;
      lit_chk(112, "old3", 4'h7, 7'h79, 1'b1);
      lit_chk(128, "new0", 4'hE, 7'h00, 1'b1);
      lit_chk(144, "new1", 4'hD, 7'h78, 1'b1);

      // Blink on digit 0 with its decimal point.
      data = 16'h12AF; dp_en = 4'b0001; blink_mask = 4'b0001;
      restart();
      lit_chk(64, "bk1", 4'hE, 7'h0E, 1'b0);
      lit_chk(128, "bk2", 4'hE, 7'h7F, 1'b1);
      lit_chk(144, "bk2d1", 4'hD, 7'h08, 1'b1);
      lit_chk(192, "bk3", 4'hE, 7'h7F, 1'b1);
      lit_chk(256, "bk4", 4'hE, 7'h0E, 1'b0);
      lit_chk(320, "bk5", 4'hE, 7'h0E, 1'b0);

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
